// File: rtl/comb_sweep_ctrl_pkg.sv
// Shared definitions for exhaustive-sweep BIST controllers: state encodings,
// default geometry and the settle counter width.
package comb_sweep_ctrl_pkg;

    localparam int unsigned DEF_N      = 3;
    localparam int unsigned DEF_SETTLE = 1;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter; tc_c flags the last settle cycle (count == 1).
module sweep_settle_cnt
    import comb_sweep_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc_c = (cnt == W'(1));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive sweep of an N-input combinational block against a golden truth
// table, with mismatch count, first failing vector and pass/fail reporting.
module comb_sweep_ctrl
    import comb_sweep_ctrl_pkg::*;
#(
    parameter int unsigned         N      = DEF_N,
    parameter int unsigned         SETTLE = DEF_SETTLE,
    parameter logic [2**N-1:0]     EXPECT = 8'b1110_1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         y,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err,
    output logic         first_err_vld
);

    localparam logic [N-1:0]     LAST_VEC   = N'(2**N - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);

    sweep_state_t state_q, state_d;
    logic [N-1:0] vec_q, vec_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic [N:0]   err_q, err_d;
    logic [N-1:0] ferr_q, ferr_d;
    logic         fvld_q, fvld_d;
    logic         cnt_load_c, cnt_en_c, cnt_tc_c;

    sweep_settle_cnt #(.W(CNT_W)) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .en       (cnt_en_c),
        .load_val (SETTLE_LD),
        .tc_c     (cnt_tc_c)
    );

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        fvld_d     = fvld_q;
        cnt_load_c = 1'b0;
        cnt_en_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    vec_d      = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    fvld_d     = 1'b0;
                    busy_d     = 1'b1;
                    cnt_load_c = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_en_c = 1'b1;
                if (cnt_tc_c) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (y != EXPECT[vec_q]) begin
                    err_d = err_q + (N+1)'(1);
                    if (!fvld_q) begin
                        ferr_d = vec_q;
                        fvld_d = 1'b1;
                    end
                end
                // The vector register stops at the last vector rather than wrapping.
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    vec_d      = vec_q + N'(1);
                    cnt_load_c = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            fvld_q  <= fvld_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err     = ferr_q;
    assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboard bench for comb_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// sweeping randomly chosen truth tables against the golden majority function.
module tb_comb_sweep_ctrl;

    localparam int S0 = 1;
    localparam int S1 = 3;
    localparam logic [7:0] GOLD = 8'b1110_1000;

    logic       clk = 1'b0;
    logic       rst   [2];
    logic       start [2];
    logic       y     [2];
    logic [2:0] vec   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [3:0] err_cnt [2];
    logic [2:0] first_err [2];
    logic       fvld  [2];

    always #5 clk = ~clk;

    comb_sweep_ctrl #(.N(3), .SETTLE(S0), .EXPECT(GOLD)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .y(y[0]), .vec(vec[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
        .first_err(first_err[0]), .first_err_vld(fvld[0])
    );

    comb_sweep_ctrl #(.N(3), .SETTLE(S1), .EXPECT(GOLD)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .y(y[1]), .vec(vec[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
        .first_err(first_err[1]), .first_err_vld(fvld[1])
    );

    typedef struct {
        int dut;
        int done_cyc;
        int err;
        int ferr;
        int fvld;
        int pass;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         c0 [2];
    logic [7:0] fn [2];
    bit         noise [2];
    bit         pend [2];
    int         pend_pass [2];
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int d);
        return (d == 1) ? S1 : S0;
    endfunction

    // Reference: mismatches are the differing bits of the two truth tables;
    // each vector costs SETTLE+1 cycles, done lands one cycle after the last.
    function automatic exp_t model(input int d, input int start_cyc, input logic [7:0] f);
        exp_t e;
        logic [7:0] g;
        g = GOLD;
        e.dut = d; e.err = 0; e.ferr = 0; e.fvld = 0;
        for (int i = 0; i < 8; i++) begin
            if (f[i] != g[i]) begin
                e.err++;
                if (e.fvld == 0) begin
                    e.ferr = i;
                    e.fvld = 1;
                end
            end
        end
        e.pass     = (e.err == 0) ? 1 : 0;
        e.done_cyc = start_cyc + 8 * (settle_of(d) + 1);
        return e;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    // Block under test: its truth table is fn; during settle cycles the
    // noisy variant toggles randomly, since only the CHECK-cycle value counts.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int k, p;
            k = cyc - c0[d] + 1;
            p = (k >= 1) ? (k - 1) % (settle_of(d) + 1) : 0;
            if (noise[d] && k >= 1 && p != settle_of(d))
                y[d] = 1'($urandom);
            else
                y[d] = fn[d][vec[d]];
        end
    end

    // Monitor: pop on every done pulse, check pass/busy one cycle later.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (pend[d]) begin
                chk("pass", d, int'(pass[d]), pend_pass[d]);
                chk("busy_after_done", d, int'(busy[d]), 0);
                pend[d] = 1'b0;
            end
            if (done[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", d, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dut_id", d, d, e.dut);
                    chk("done_cycle", d, cyc, e.done_cyc);
                    chk("err_cnt", d, int'(err_cnt[d]), e.err);
                    chk("first_err_vld", d, int'(fvld[d]), e.fvld);
                    if (e.fvld != 0) chk("first_err", d, int'(first_err[d]), e.ferr);
                    chk("vec_last", d, int'(vec[d]), 7);
                    chk("busy_in_done", d, int'(busy[d]), 1);
                    pend[d]      = 1'b1;
                    pend_pass[d] = e.pass;
                end
            end
        end
    end

    task automatic chk_reset(input int d);
        chk("rst_vec", d, int'(vec[d]), 0);
        chk("rst_busy", d, int'(busy[d]), 0);
        chk("rst_done", d, int'(done[d]), 0);
        chk("rst_pass", d, int'(pass[d]), 0);
        chk("rst_err_cnt", d, int'(err_cnt[d]), 0);
        chk("rst_first_err", d, int'(first_err[d]), 0);
        chk("rst_first_err_vld", d, int'(fvld[d]), 0);
    endtask

    task automatic issue(input int d, input logic [7:0] f, input bit nz);
        fn[d]    = f;
        noise[d] = nz;
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        c0[d]    = cyc;
        sb.push_back(model(d, cyc, f));
    endtask

    // Bounded wait; optional start pokes while busy must be ignored.
    task automatic wait_sweep(input int d, input bit poke);
        int len;
        len = 8 * (settle_of(d) + 1) + 1;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clk);
            start[d] = poke && (k == 5 || k == 12);
        end
        start[d] = 1'b0;
        chk("sweep_completed", d, sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    function automatic logic [7:0] rand_fn();
        logic [7:0] r;
        r = 8'($urandom);
        return ($urandom_range(0, 2) == 0) ? GOLD : r;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; fn[d] = GOLD;
            noise[d] = 1'b0; c0[d] = -1000; pend[d] = 1'b0; pend_pass[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);

        // Directed: golden, stuck-at-0, inverted majority.
        issue(0, GOLD, 1'b0);   wait_sweep(0, 1'b0);
        issue(0, 8'h00, 1'b0);  wait_sweep(0, 1'b0);
        issue(0, 8'h17, 1'b0);  wait_sweep(0, 1'b0);

        // Reset in cycle 6 discards the sweep; a fresh sweep then passes.
        issue(0, 8'h00, 1'b0);
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst[0] = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk_reset(0);
        issue(0, GOLD, 1'b0);   wait_sweep(0, 1'b0);

        // start pulses while busy are ignored.
        issue(0, 8'h5a, 1'b0);  wait_sweep(0, 1'b1);

        // Held start retriggers right after DONE -> IDLE (period 18 cycles).
        fn[0] = rand_fn();
        noise[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        c0[0] = cyc;
        sb.push_back(model(0, cyc, fn[0]));
        sb.push_back(model(0, cyc + 18, fn[0]));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 19) start[0] = 1'b0;
        end
        chk("held_start_sweeps", 0, sb.size(), 0);
        sb.delete();

        for (int i = 0; i < 6; i++) begin
            issue(0, rand_fn(), 1'b0);
            wait_sweep(0, 1'b0);
        end

        // SETTLE=3 instance with y toggling during settle cycles.
        issue(1, GOLD, 1'b1);   wait_sweep(1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            issue(1, rand_fn(), 1'b1);
            wait_sweep(1, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comb_sweep_ctrl.md
# comb_sweep_ctrl

Self-checking sweep controller for small combinational blocks (N-input, 1-output functions such as `comb_Y1`). On `start` it drives every input vector from 0 to 2^N−1 into the combinational block under test. For each vector it waits a programmable settle time, then compares the block's output against a golden truth table and accumulates mismatches. It sits beside the combinational datapath as the on-chip replacement for the exhaustive-sweep testbenches, and reports pass/fail, error count and the first failing vector.

## Interface
Parameters:
- `N`, 3, number of combinational inputs; sweep length is 2^N.
- `SETTLE`, 1, cycles to hold each vector before sampling; legal range 1..15.
- `EXPECT`, 8'b1110_1000, golden truth table (2^N bits); bit i is the expected `y` for input vector i.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `y`  in  1  output of the combinational block under test.
- `vec`  out  N  input vector driven to the block, MSB = A.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `pass`  out  1  last sweep had zero mismatches; held until next start.
- `err_cnt`  out  N+1  mismatch count for the current or last sweep.
- `first_err`  out  N  vector index of the first mismatch.
- `first_err_vld`  out  1  `first_err` is valid.

## Operation
- The FSM has four states:
  - IDLE: `start` → SETTLE, with `vec`←0, `err_cnt`←0, `pass`←0, `first_err_vld`←0, `busy`←1, and the settle counter ← SETTLE.
  - SETTLE: the settle counter decrements each cycle; at count 1 → CHECK.
  - CHECK: compare `y` with `EXPECT[vec]`.
    - On mismatch: `err_cnt`+1. If `first_err_vld`=0, `first_err`←`vec` and `first_err_vld`←1.
    - If `vec`=2^N−1 → DONE. Otherwise `vec`←`vec`+1, reload the settle counter, → SETTLE.
  - DONE: `done`=1 for exactly this cycle, `pass`←(`err_cnt`==0), → IDLE, `busy`←0 on exit.
- `vec` does not wrap after the last vector. It holds 2^N−1 until the next `start`.
- `err_cnt` is N+1 bits so it can hold a full-sweep failure (2^N) without overflow.
- `start` is ignored outside IDLE. A held `start` in IDLE retriggers a new sweep immediately after DONE→IDLE.
- `first_err`, `err_cnt` and `pass` remain stable in IDLE until the next accepted `start`.

## Timing
- All outputs are registered.
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err`=0, `first_err_vld`=0, state IDLE.
- Each vector takes SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in CHECK.
- `y` is sampled on the clock edge that ends the CHECK cycle.
- Latency: with `start` accepted at edge 0, `done` is high during cycle 2^N·(SETTLE+1)+1. For the defaults that is cycle 17. `busy` is high for cycles 1..17.
- Reset mid-sweep: at the next edge, all outputs take their reset values and partial results are discarded.
- `rst` and `start` in the same cycle: `rst` wins and the FSM stays in IDLE.
- A mismatch on the last vector is counted before `pass` is computed. The DONE cycle uses the updated `err_cnt`.

## Structure
- Shared include `comb_sweep_defs.vh`: state encodings (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3) and default `N`/`SETTLE` values, reused by future sweep/BIST blocks.
- One natural sub-module, `sweep_settle_cnt`: a loadable down-counter with a terminal-count flag that drives SETTLE→CHECK.
- Everything else (FSM, vector register, error bookkeeping) lives in `comb_sweep_ctrl`.

## Test plan
- Golden majority DUT (`EXPECT`=8'b1110_1000, `y` = majority of `vec`), `start` pulse → `done` in cycle 17, `err_cnt`=0, `pass`=1, `first_err_vld`=0, `vec`=3'b111 afterward.
- `y` stuck at 0 → `err_cnt`=4, `first_err`=3, `first_err_vld`=1, `pass`=0.
- `y` = inverted majority → `err_cnt`=8 (no overflow), `first_err`=0, `pass`=0.
- `rst` asserted at cycle 6 of a sweep, then `start` again → all outputs at reset values at cycle 7, and the second sweep completes with `err_cnt`=0, `pass`=1.
- `start` pulsed at cycles 5 and 12 while `busy` → ignored: exactly one `done`, still in cycle 17.
- `SETTLE`=3, correct DUT → each vector held for 4 cycles, `done` in cycle 33, and `y` changes during settle cycles do not affect `err_cnt`.
